carpma_birimi: RTL and testbench

CARPMA_BIRIMI -- requirements
Module: carpma_birimi

---
 rtl/carpma_birimi_pkg.sv | 26 ++
 rtl/carpma_birimi_carpim_dizisi.sv | 36 +++
 rtl/carpma_birimi.sv | 205 ++++++++++++++++++++
 tb/tb_carpma_birimi.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/carpma_birimi_pkg.sv
// Shared definitions for the multiply unit: operation encodings,
// tag width, operand magnitude and result-half selection helpers.
package carpma_paket;

   localparam int ETIKET_W = 5;

   typedef enum logic [1:0] {
      ISLEM_MUL    = 2'b00,
      ISLEM_MULH   = 2'b01,
      ISLEM_MULHSU = 2'b10,
      ISLEM_MULHU  = 2'b11
   } islem_e;

   // Negate a signed operand to its 32-bit unsigned magnitude.
   // 0x80000000 maps to itself, which is its correct magnitude.
   function automatic logic [31:0] buyukluk(input logic [31:0] x,
                                           input logic        isaretli);
      return (isaretli && x[31]) ? (~x + 32'd1) : x;
   endfunction

   function automatic logic [31:0] sonuc_sec(input islem_e      op,
                                            input logic [63:0] p);
      return (op == ISLEM_MUL) ? p[31:0] : p[63:32];
   endfunction

endpackage

// File: rtl/carpma_birimi_carpim_dizisi.sv
// Combinational unsigned 32x32->64 multiplier: carry-save reduction
// of the partial products followed by one final carry-propagate adder.
// Ports: carpan_i, carpilan_i (operands), carpim_o (64-bit product).
module carpim_dizisi (
   input  logic [31:0] carpan_i,
   input  logic [31:0] carpilan_i,
   output logic [63:0] carpim_o
);

   logic [63:0] toplam;
   logic [63:0] elde;
   logic [63:0] kismi;
   logic [63:0] yeni_toplam;
   logic [63:0] yeni_elde;

   // Each row is a 3:2 compression of (sum, carry, partial product);
   // only the last step propagates carries.
   always_comb begin
      toplam      = '0;
      elde        = '0;
      kismi       = '0;
      yeni_toplam = '0;
      yeni_elde   = '0;
      for (int i = 0; i < 32; i++) begin
         kismi       = carpilan_i[i] ? ({32'd0, carpan_i} << i) : 64'd0;
         yeni_toplam = toplam ^ elde ^ kismi;
         yeni_elde   = ((toplam & elde) | (toplam & kismi)
                       | (elde & kismi)) << 1;
         toplam      = yeni_toplam;
         elde        = yeni_elde;
      end
   end

   assign carpim_o = toplam + elde;

endmodule

// File: rtl/carpma_birimi.sv
// RV32M multiply unit: two registered stages (A: magnitudes/sign/op/tag,
// B: selected 32-bit result/tag) with valid/ready handshakes and flush.
// Ports: clk_i, rstn_i (async active-low), istek_* request handshake,
// islem_i op, islec0_i/islec1_i operands, etiket_i tag, temizle_i flush,
// sonuc_* result handshake, sonuc_o result, etiket_o result tag.
// Optional macro CARPMA_ONBELLEK_EN adds a one-entry product cache that
// lets a repeated product bypass stage A (latency 1 instead of 2).
module carpma_birimi
   import carpma_paket::*;
(
   input  logic                clk_i,
   input  logic                rstn_i,
   input  logic                istek_gecerli_i,
   output logic                istek_hazir_o,
   input  logic [1:0]          islem_i,
   input  logic [31:0]         islec0_i,
   input  logic [31:0]         islec1_i,
   input  logic [ETIKET_W-1:0] etiket_i,
   input  logic                temizle_i,
   output logic                sonuc_gecerli_o,
   input  logic                sonuc_hazir_i,
   output logic [31:0]         sonuc_o,
   output logic [ETIKET_W-1:0] etiket_o
);

   islem_e              istek_islem;
   logic                isaretli0;
   logic                isaretli1;
   logic [31:0]         istek_mag0;
   logic [31:0]         istek_mag1;
   logic                istek_neg;

   logic                a_gecerli_q, a_gecerli_d;
   logic [31:0]         a_mag0_q, a_mag0_d;
   logic [31:0]         a_mag1_q, a_mag1_d;
   logic                a_neg_q, a_neg_d;
   islem_e              a_islem_q, a_islem_d;
   logic [ETIKET_W-1:0] a_etiket_q, a_etiket_d;

   logic                b_gecerli_q, b_gecerli_d;
   logic [31:0]         b_sonuc_q, b_sonuc_d;
   logic [ETIKET_W-1:0] b_etiket_q, b_etiket_d;

   logic [63:0]         carpim;
   logic [63:0]         carpim_isaretli;
   logic                b_aktar;
   logic                b_bos;
   logic                a_ilerle;
   logic                kabul;
   logic                onbellek_isabet;
   logic [31:0]         onbellek_sonuc;

   // The low half of a product does not depend on operand signedness,
   // so MUL uses the same signed magnitude form as MULH; this lets a
   // MUL following a MULH on the same operands hit the product cache.
   always_comb begin
      istek_islem = islem_e'(islem_i);
      isaretli0   = 1'b0;
      isaretli1   = 1'b0;
      case (istek_islem)
         ISLEM_MUL:    begin isaretli0 = 1'b1; isaretli1 = 1'b1; end
         ISLEM_MULH:   begin isaretli0 = 1'b1; isaretli1 = 1'b1; end
         ISLEM_MULHSU: begin isaretli0 = 1'b1; isaretli1 = 1'b0; end
         default:      begin isaretli0 = 1'b0; isaretli1 = 1'b0; end
      endcase
      istek_mag0 = buyukluk(islec0_i, isaretli0);
      istek_mag1 = buyukluk(islec1_i, isaretli1);
      istek_neg  = (isaretli0 & islec0_i[31]) ^ (isaretli1 & islec1_i[31]);
   end

   carpim_dizisi u_dizi (
      .carpan_i   (a_mag0_q),
      .carpilan_i (a_mag1_q),
      .carpim_o   (carpim)
   );

   assign carpim_isaretli = a_neg_q ? (~carpim + 64'd1) : carpim;

   assign b_aktar  = b_gecerli_q & sonuc_hazir_i;
   assign b_bos    = !b_gecerli_q | b_aktar;
   assign a_ilerle = a_gecerli_q & b_bos;

   // Gated by rstn_i so the unit reports not-ready while held in reset.
   assign istek_hazir_o = rstn_i & !temizle_i & (!a_gecerli_q | a_ilerle);
   assign kabul         = istek_gecerli_i & istek_hazir_o;

`ifdef CARPMA_ONBELLEK_EN
   logic        onb_gecerli_q, onb_gecerli_d;
   logic [31:0] onb_mag0_q, onb_mag0_d;
   logic [31:0] onb_mag1_q, onb_mag1_d;
   logic        onb_neg_q, onb_neg_d;
   logic [63:0] onb_carpim_q, onb_carpim_d;

   always_comb begin
      onb_gecerli_d = onb_gecerli_q;
      onb_mag0_d    = onb_mag0_q;
      onb_mag1_d    = onb_mag1_q;
      onb_neg_d     = onb_neg_q;
      onb_carpim_d  = onb_carpim_q;
      if (temizle_i) begin
         onb_gecerli_d = 1'b0;
      end else if (a_ilerle) begin
         onb_gecerli_d = 1'b1;
         onb_mag0_d    = a_mag0_q;
         onb_mag1_d    = a_mag1_q;
         onb_neg_d     = a_neg_q;
         onb_carpim_d  = carpim_isaretli;
      end
   end

   // Bypass only when A is empty, so a hit can never overtake an
   // older request still in A.
   assign onbellek_isabet = kabul & onb_gecerli_q & !a_gecerli_q & b_bos
                          & (istek_mag0 == onb_mag0_q)
                          & (istek_mag1 == onb_mag1_q)
                          & (istek_neg == onb_neg_q);
   assign onbellek_sonuc  = sonuc_sec(istek_islem, onb_carpim_q);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         onb_gecerli_q <= 1'b0;
         onb_mag0_q    <= '0;
         onb_mag1_q    <= '0;
         onb_neg_q     <= 1'b0;
         onb_carpim_q  <= '0;
      end else begin
         onb_gecerli_q <= onb_gecerli_d;
         onb_mag0_q    <= onb_mag0_d;
         onb_mag1_q    <= onb_mag1_d;
         onb_neg_q     <= onb_neg_d;
         onb_carpim_q  <= onb_carpim_d;
      end
   end
`else
   assign onbellek_isabet = 1'b0;
   assign onbellek_sonuc  = '0;
`endif

   always_comb begin
      a_gecerli_d = a_gecerli_q;
      a_mag0_d    = a_mag0_q;
      a_mag1_d    = a_mag1_q;
      a_neg_d     = a_neg_q;
      a_islem_d   = a_islem_q;
      a_etiket_d  = a_etiket_q;
      b_gecerli_d = b_gecerli_q;
      b_sonuc_d   = b_sonuc_q;
      b_etiket_d  = b_etiket_q;
      if (temizle_i) begin
         a_gecerli_d = 1'b0;
         b_gecerli_d = 1'b0;
      end else begin
         if (a_ilerle) begin
            b_gecerli_d = 1'b1;
            b_sonuc_d   = sonuc_sec(a_islem_q, carpim_isaretli);
            b_etiket_d  = a_etiket_q;
         end else if (onbellek_isabet) begin
            b_gecerli_d = 1'b1;
            b_sonuc_d   = onbellek_sonuc;
            b_etiket_d  = etiket_i;
         end else if (b_aktar) begin
            b_gecerli_d = 1'b0;
         end
         if (kabul && !onbellek_isabet) begin
            a_gecerli_d = 1'b1;
            a_mag0_d    = istek_mag0;
            a_mag1_d    = istek_mag1;
            a_neg_d     = istek_neg;
            a_islem_d   = istek_islem;
            a_etiket_d  = etiket_i;
         end else if (a_ilerle) begin
            a_gecerli_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         a_gecerli_q <= 1'b0;
         a_mag0_q    <= '0;
         a_mag1_q    <= '0;
         a_neg_q     <= 1'b0;
         a_islem_q   <= ISLEM_MUL;
         a_etiket_q  <= '0;
         b_gecerli_q <= 1'b0;
         b_sonuc_q   <= '0;
         b_etiket_q  <= '0;
      end else begin
         a_gecerli_q <= a_gecerli_d;
         a_mag0_q    <= a_mag0_d;
         a_mag1_q    <= a_mag1_d;
         a_neg_q     <= a_neg_d;
         a_islem_q   <= a_islem_d;
         a_etiket_q  <= a_etiket_d;
         b_gecerli_q <= b_gecerli_d;
         b_sonuc_q   <= b_sonuc_d;
         b_etiket_q  <= b_etiket_d;
      end
   end

   assign sonuc_gecerli_o = b_gecerli_q;
   assign sonuc_o         = b_sonuc_q;
   assign etiket_o        = b_etiket_q;

endmodule

// File: tb/tb_carpma_birimi.sv
// Directed self-checking bench for carpma_birimi.
// Expected latency of the repeated-product case follows CARPMA_ONBELLEK_EN.
module tb_carpma_birimi;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic        istek_gecerli_i;
   logic        istek_hazir_o;
   logic [1:0]  islem_i;
   logic [31:0] islec0_i;
   logic [31:0] islec1_i;
   logic [4:0]  etiket_i;
   logic        temizle_i;
   logic        sonuc_gecerli_o;
   logic        sonuc_hazir_i;
   logic [31:0] sonuc_o;
   logic [4:0]  etiket_o;

   int checks   = 0;
   int failures = 0;

   logic [31:0] q_res[$];
   logic [4:0]  q_tag[$];

   localparam logic [1:0] MUL    = 2'b00;
   localparam logic [1:0] MULH   = 2'b01;
   localparam logic [1:0] MULHSU = 2'b10;
   localparam logic [1:0] MULHU  = 2'b11;

   carpma_birimi dut (
      .clk_i           (clk_i),
      .rstn_i          (rstn_i),
      .istek_gecerli_i (istek_gecerli_i),
      .istek_hazir_o   (istek_hazir_o),
      .islem_i         (islem_i),
      .islec0_i        (islec0_i),
      .islec1_i        (islec1_i),
      .etiket_i        (etiket_i),
      .temizle_i       (temizle_i),
      .sonuc_gecerli_o (sonuc_gecerli_o),
      .sonuc_hazir_i   (sonuc_hazir_i),
      .sonuc_o         (sonuc_o),
      .etiket_o        (etiket_o)
   );

   always #5 clk_i = ~clk_i;

   // Record every completed transfer (flush cycles discard theirs).
   always @(negedge clk_i) begin
      if (rstn_i === 1'b1 && sonuc_gecerli_o && sonuc_hazir_i && !temizle_i) begin
         q_res.push_back(sonuc_o);
         q_tag.push_back(etiket_o);
      end
   end

   task automatic adim();
      @(posedge clk_i);
      #1;
   endtask

   task automatic yukle(input int t);
      case (t)
         1: begin islem_i = MUL; islec0_i = 32'd3; islec1_i = 32'd5; end
         2: begin islem_i = MUL; islec0_i = 32'd6; islec1_i = 32'd7; end
         default: begin
            islem_i = MULHU; islec0_i = 32'h0001_0000; islec1_i = 32'h0003_0000;
         end
      endcase
      etiket_i = 5'(t);
   endtask

   task automatic istek_ver(input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [4:0] t,
                            output logic [31:0] r, output logic [4:0] rt,
                            output int lat);
      bit ok;
      ok = 1'b0;
      islem_i = op; islec0_i = a; islec1_i = b; etiket_i = t;
      istek_gecerli_i = 1'b1;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk_i);
         ok = istek_hazir_o;
         adim();
      end
      istek_gecerli_i = 1'b0;
      r = '0; rt = '0; lat = 99;
      if (ok) begin
         lat = 1;
         while (!sonuc_gecerli_o && lat < 10) begin
            adim();
            lat++;
         end
         r = sonuc_o;
         rt = etiket_o;
         adim();
      end
   endtask

   task automatic test_reset();
      rstn_i = 1'b0; istek_gecerli_i = 1'b1; temizle_i = 1'b0;
      sonuc_hazir_i = 1'b1; yukle(1);
      #2;
      checks++; if (sonuc_gecerli_o !== 1'b0) begin failures++;
         $display("FAIL reset_valid got=%b exp=0", sonuc_gecerli_o); end
      checks++; if (istek_hazir_o !== 1'b0) begin failures++;
         $display("FAIL reset_ready got=%b exp=0", istek_hazir_o); end
      checks++; if (sonuc_o !== 32'h0) begin failures++;
         $display("FAIL reset_result got=%h exp=0", sonuc_o); end
      checks++; if (etiket_o !== 5'h0) begin failures++;
         $display("FAIL reset_tag got=%h exp=0", etiket_o); end
      istek_gecerli_i = 1'b0;
      repeat (2) adim();
      rstn_i = 1'b1;
      #1;
      checks++; if (istek_hazir_o !== 1'b1) begin failures++;
         $display("FAIL release_ready got=%b exp=1", istek_hazir_o); end
      adim();
   endtask

   task automatic test_unsigned();
      logic [31:0] r; logic [4:0] rt; int lat;
      istek_ver(MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, r, rt, lat);
      checks++; if (r !== 32'hFFFF_FFFE) begin failures++;
         $display("FAIL mulhu_result got=%h exp=fffffffe", r); end
      checks++; if (rt !== 5'd5) begin failures++;
         $display("FAIL mulhu_tag got=%0d exp=5", rt); end
      checks++; if (lat != 2) begin failures++;
         $display("FAIL mulhu_latency got=%0d exp=2", lat); end
      istek_ver(MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, r, rt, lat);
      checks++; if (r !== 32'h0000_0001) begin failures++;
         $display("FAIL mul_result got=%h exp=00000001", r); end
      checks++; if (rt !== 5'd6) begin failures++;
         $display("FAIL mul_tag got=%0d exp=6", rt); end
      checks++; if (lat != 2) begin failures++;
         $display("FAIL mul_latency got=%0d exp=2", lat); end
   endtask

   task automatic test_signed();
      logic [31:0] r; logic [4:0] rt; int lat;
      istek_ver(MULH, 32'h8000_0000, 32'h8000_0000, 5'd7, r, rt, lat);
      checks++; if (r !== 32'h4000_0000) begin failures++;
         $display("FAIL mulh_min_result got=%h exp=40000000", r); end
      istek_ver(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, r, rt, lat);
      checks++; if (r !== 32'hFFFF_FFFF) begin failures++;
         $display("FAIL mulhsu_result got=%h exp=ffffffff", r); end
      istek_ver(MULH, 32'h0, 32'hFFFF_FFFF, 5'd9, r, rt, lat);
      checks++; if (r !== 32'h0) begin failures++;
         $display("FAIL mulh_zero_result got=%h exp=00000000", r); end
   endtask

   task automatic test_back_to_back();
      int n; bit acc; logic [31:0] bek_r [0:2]; logic [4:0] bek_t [0:2];
      bek_r[0] = 32'd15; bek_r[1] = 32'd42; bek_r[2] = 32'd3;
      bek_t[0] = 5'd1;   bek_t[1] = 5'd2;   bek_t[2] = 5'd3;
      q_res.delete(); q_tag.delete();
      n = 0; sonuc_hazir_i = 1'b0;
      yukle(1); istek_gecerli_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i); acc = istek_hazir_o; adim();
         if (acc) begin n++; yukle(n + 1); end
      end
      checks++; if (n != 2) begin failures++;
         $display("FAIL b2b_accepted got=%0d exp=2", n); end
      checks++; if (istek_hazir_o !== 1'b0) begin failures++;
         $display("FAIL b2b_stall_ready got=%b exp=0", istek_hazir_o); end
      checks++; if (sonuc_gecerli_o !== 1'b1 || sonuc_o !== 32'd15 || etiket_o !== 5'd1) begin
         failures++;
         $display("FAIL b2b_hold got=%b/%h/%0d exp=1/0000000f/1",
                  sonuc_gecerli_o, sonuc_o, etiket_o); end
      sonuc_hazir_i = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 10 && !acc; c++) begin
         @(negedge clk_i); acc = istek_hazir_o; adim();
      end
      istek_gecerli_i = 1'b0;
      for (int c = 0; c < 20 && q_res.size() < 3; c++) adim();
      checks++; if (q_res.size() != 3) begin failures++;
         $display("FAIL b2b_count got=%0d exp=3", q_res.size()); end
      for (int i = 0; i < 3 && i < q_res.size(); i++) begin
         checks++;
         if (q_tag[i] !== bek_t[i] || q_res[i] !== bek_r[i]) begin failures++;
            $display("FAIL b2b_order[%0d] got=%0d/%h exp=%0d/%h",
                     i, q_tag[i], q_res[i], bek_t[i], bek_r[i]); end
      end
   endtask

   task automatic test_flush();
      int n; bit acc; logic [31:0] r; logic [4:0] rt; int lat;
      q_res.delete(); q_tag.delete();
      n = 0; sonuc_hazir_i = 1'b0;
      yukle(1); istek_gecerli_i = 1'b1;
      for (int c = 0; c < 6 && n < 2; c++) begin
         @(negedge clk_i); acc = istek_hazir_o; adim();
         if (acc) begin n++; yukle(n + 1); end
      end
      checks++; if (n != 2 || sonuc_gecerli_o !== 1'b1) begin failures++;
         $display("FAIL flush_fill got=%0d/%b exp=2/1", n, sonuc_gecerli_o); end
      temizle_i = 1'b1; sonuc_hazir_i = 1'b1;
      #1;
      checks++; if (istek_hazir_o !== 1'b0) begin failures++;
         $display("FAIL flush_ready got=%b exp=0", istek_hazir_o); end
      adim();
      temizle_i = 1'b0; istek_gecerli_i = 1'b0;
      checks++; if (sonuc_gecerli_o !== 1'b0) begin failures++;
         $display("FAIL flush_valid got=%b exp=0", sonuc_gecerli_o); end
      repeat (4) adim();
      checks++; if (q_res.size() != 0) begin failures++;
         $display("FAIL flush_stale got=%0d exp=0", q_res.size()); end
      istek_ver(MULHU, 32'h0001_0000, 32'h0003_0000, 5'd9, r, rt, lat);
      checks++; if (r !== 32'd3 || rt !== 5'd9) begin failures++;
         $display("FAIL flush_next got=%h/%0d exp=00000003/9", r, rt); end
      checks++; if (lat != 2) begin failures++;
         $display("FAIL flush_next_latency got=%0d exp=2", lat); end
   endtask

   task automatic test_reset_mid();
      bit acc;
      yukle(1); etiket_i = 5'd4; istek_gecerli_i = 1'b1;
      @(negedge clk_i); acc = istek_hazir_o; adim();
      istek_gecerli_i = 1'b0;
      checks++; if (acc !== 1'b1) begin failures++;
         $display("FAIL rstmid_accept got=%b exp=1", acc); end
      rstn_i = 1'b0;
      #1;
      checks++; if (sonuc_gecerli_o !== 1'b0 || istek_hazir_o !== 1'b0) begin failures++;
         $display("FAIL rstmid_ctrl got=%b/%b exp=0/0", sonuc_gecerli_o, istek_hazir_o); end
      checks++; if (sonuc_o !== 32'h0 || etiket_o !== 5'h0) begin failures++;
         $display("FAIL rstmid_data got=%h/%0d exp=0/0", sonuc_o, etiket_o); end
      adim();
      rstn_i = 1'b1;
      q_res.delete(); q_tag.delete();
      #1;
      checks++; if (istek_hazir_o !== 1'b1) begin failures++;
         $display("FAIL rstmid_release_ready got=%b exp=1", istek_hazir_o); end
      repeat (5) adim();
      checks++; if (q_res.size() != 0 || sonuc_gecerli_o !== 1'b0) begin failures++;
         $display("FAIL rstmid_no_result got=%0d/%b exp=0/0", q_res.size(), sonuc_gecerli_o); end
   endtask

   task automatic test_cache();
      logic [31:0] r; logic [4:0] rt; int lat; int bek_lat;
`ifdef CARPMA_ONBELLEK_EN
      bek_lat = 1;
`else
      bek_lat = 2;
`endif
      istek_ver(MULH, 32'd7, 32'hFFFF_FFFD, 5'd10, r, rt, lat);
      checks++; if (r !== 32'hFFFF_FFFF || rt !== 5'd10) begin failures++;
         $display("FAIL cache_mulh got=%h/%0d exp=ffffffff/10", r, rt); end
      checks++; if (lat != 2) begin failures++;
         $display("FAIL cache_mulh_latency got=%0d exp=2", lat); end
      istek_ver(MUL, 32'd7, 32'hFFFF_FFFD, 5'd11, r, rt, lat);
      checks++; if (r !== 32'hFFFF_FFEB || rt !== 5'd11) begin failures++;
         $display("FAIL cache_mul got=%h/%0d exp=ffffffeb/11", r, rt); end
      checks++; if (lat != bek_lat) begin failures++;
         $display("FAIL cache_mul_latency got=%0d exp=%0d", lat, bek_lat); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_unsigned();
      test_signed();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_cache();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
